// File: rtl/game_pkg.sv
// Shared definitions for the 2048 board string parser: board geometry, parser states,
// error codes, ASCII constants and the power-of-two tile test.
package game_pkg;

  localparam int TILE_W    = 20;
  localparam int NUM_TILES = 16;
  localparam int BOARD_W   = TILE_W * NUM_TILES;
  localparam int IDX_W     = $clog2(NUM_TILES) + 1;

  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(NUM_TILES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NUM,
    ST_PUBLISH,
    ST_SKIP
  } parse_state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_CHAR = 3'd1;
  localparam logic [2:0] ERR_OVERFLOW = 3'd2;
  localparam logic [2:0] ERR_TOO_MANY = 3'd3;
  localparam logic [2:0] ERR_TOO_FEW  = 3'd4;
  localparam logic [2:0] ERR_NOT_POW2 = 3'd5;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  // Legal tile: empty (0) or a single set bit other than bit 0.
  function automatic logic tile_is_pow2(input logic [TILE_W-1:0] v);
    return (v == '0) || (($countones(v) == 1) && (v != TILE_W'(1)));
  endfunction

endpackage

// File: rtl/string_to_board_if.sv
// Character-in / board-out bundle of the board string parser; master feeds characters,
// slave (the parser) returns char_ready, the published board and error pulses.
interface string_to_board_if;
  import game_pkg::*;

  logic [7:0]         char_in;
  logic               char_valid;
  logic               char_ready;
  logic [BOARD_W-1:0] board;
  logic               board_valid;
  logic               err_valid;
  logic [2:0]         err_code;

  modport master (
    output char_in, char_valid,
    input  char_ready, board, board_valid, err_valid, err_code
  );

  modport slave (
    input  char_in, char_valid,
    output char_ready, board, board_valid, err_valid, err_code
  );

endinterface

// File: rtl/string_to_board_ascii_dec_accum.sv
// Decimal accumulator: acc <= d or acc*10+d on the cycle after the control strobe,
// saturating at 2^TILE_W-1 with a sticky overflow flag; no backpressure of its own.
module ascii_dec_accum
  import game_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              accum,
  input  logic [3:0]        digit,
  output logic [TILE_W-1:0] acc,
  output logic              ovf
);

  localparam logic [TILE_W+3:0] LIMIT = {4'b0, {TILE_W{1'b1}}};

  logic [TILE_W+3:0] next_val;

  // Four guard bits hold (2^TILE_W-1)*10+9 without wrapping.
  assign next_val = {4'b0, acc} * (TILE_W+4)'(10) + (TILE_W+4)'(digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      acc <= TILE_W'(digit);
      ovf <= 1'b0;
    end else if (accum) begin
      if (next_val > LIMIT) begin
        acc <= LIMIT[TILE_W-1:0];
        ovf <= 1'b1;
      end else begin
        acc <= next_val[TILE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/string_to_board.sv
// ASCII line -> packed 2048 board; define STRING_TO_BOARD_POW2_CHECK_EN to reject non-power-of-two tiles.
// Latency: board_valid/err_valid pulse one cycle after the newline or the offending char.
// Backpressure: char_ready drops only in the PUBLISH cycle.
module string_to_board
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  string_to_board_if.slave bus
);

  parse_state_t       state;
  logic [IDX_W-1:0]   tile_idx;
  logic [BOARD_W-1:0] staging;
  logic [BOARD_W-1:0] staging_nxt;
  logic [BOARD_W-1:0] board_q;
  logic               board_valid_q;
  logic               err_valid_q;
  logic [2:0]         err_code_q;
  logic               char_ready_q;

  logic               xfer, is_digit, is_sep, is_dot, is_nl, is_cr;
  logic               acc_clr, acc_load, acc_accum;
  logic               store_req, store_ok, eol, bad;
  logic [TILE_W-1:0]  acc, store_val;
  logic               acc_ovf;
  logic [2:0]         store_code;
  logic [IDX_W-1:0]   count_nxt;

  ascii_dec_accum u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .load  (acc_load),
    .accum (acc_accum),
    .digit (bus.char_in[3:0]),
    .acc   (acc),
    .ovf   (acc_ovf)
  );

  always_comb begin
    xfer      = bus.char_valid && char_ready_q;
    is_digit  = (bus.char_in >= CH_0) && (bus.char_in <= CH_9);
    is_sep    = (bus.char_in == CH_SP) || (bus.char_in == CH_COMMA);
    is_dot    = (bus.char_in == CH_DOT);
    is_nl     = (bus.char_in == CH_NL);
    is_cr     = (bus.char_in == CH_CR);
    acc_load  = 1'b0;
    acc_accum = 1'b0;
    store_req = 1'b0;
    store_val = acc;
    eol       = 1'b0;
    bad       = 1'b0;
    if (xfer && !is_cr) begin
      case (state)
        ST_IDLE: begin
          if (is_digit)    acc_load = 1'b1;
          else if (is_dot) begin store_req = 1'b1; store_val = '0; end
          else if (is_nl)  eol = 1'b1;
          else if (!is_sep) bad = 1'b1;
        end
        ST_NUM: begin
          if (is_digit)    acc_accum = 1'b1;
          else if (is_sep) store_req = 1'b1;
          else if (is_nl)  begin store_req = 1'b1; eol = 1'b1; end
          else             bad = 1'b1;
        end
        default: ;
      endcase
    end
    acc_clr = eol || (state == ST_PUBLISH) || ((state == ST_SKIP) && xfer && is_nl);

    store_code = ERR_NONE;
    if (tile_idx == IDX_FULL)               store_code = ERR_TOO_MANY;
    else if ((state == ST_NUM) && acc_ovf)  store_code = ERR_OVERFLOW;
`ifdef STRING_TO_BOARD_POW2_CHECK_EN
    else if (!tile_is_pow2(store_val))      store_code = ERR_NOT_POW2;
`endif
    store_ok  = store_req && (store_code == ERR_NONE);
    count_nxt = tile_idx + IDX_W'(store_ok);

    staging_nxt = staging;
    if (store_ok) staging_nxt[TILE_W*tile_idx[IDX_W-2:0] +: TILE_W] = store_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      tile_idx      <= '0;
      staging       <= '0;
      board_q       <= '0;
      board_valid_q <= 1'b0;
      err_valid_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      char_ready_q  <= 1'b1;
    end else begin
      board_valid_q <= 1'b0;
      err_valid_q   <= 1'b0;
      char_ready_q  <= 1'b1;
      case (state)
        ST_PUBLISH: begin
          state    <= ST_IDLE;
          tile_idx <= '0;
        end
        ST_SKIP: begin
          if (xfer && is_nl) begin
            state    <= ST_IDLE;
            tile_idx <= '0;
          end
        end
        default: begin
          if (bad) begin
            err_valid_q <= 1'b1;
            err_code_q  <= ERR_BAD_CHAR;
            state       <= ST_SKIP;
          end else if (store_req && !store_ok) begin
            err_valid_q <= 1'b1;
            err_code_q  <= store_code;
            // A failing store on the newline already ends the line; nothing left to skip.
            if (eol) begin
              state    <= ST_IDLE;
              tile_idx <= '0;
            end else begin
              state <= ST_SKIP;
            end
          end else begin
            if (store_ok) begin
              staging  <= staging_nxt;
              tile_idx <= count_nxt;
            end
            if (eol) begin
              tile_idx <= '0;
              if (count_nxt == IDX_FULL) begin
                board_q       <= staging_nxt;
                board_valid_q <= 1'b1;
                char_ready_q  <= 1'b0;
                state         <= ST_PUBLISH;
              end else begin
                state <= ST_IDLE;
                if (count_nxt != '0) begin
                  err_valid_q <= 1'b1;
                  err_code_q  <= ERR_TOO_FEW;
                end
              end
            end else if (acc_load) begin
              state <= ST_NUM;
            end else if (store_ok) begin
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign bus.char_ready  = char_ready_q;
  assign bus.board       = board_q;
  assign bus.board_valid = board_valid_q;
  assign bus.err_valid   = err_valid_q;
  assign bus.err_code    = err_code_q;

endmodule

// File: doc/string_to_board.md
Name: string_to_board

Overview:
- Parses a serial ASCII character stream describing a 2048 board and rebuilds the packed 320-bit board word from it.
- Each line holds 16 decimal tile values in row-major order and ends with a newline.
- It is the inverse of the board-to-display-string path. It is used for loading boards over the UART and for scripted board injection in tests.

Parameters:
- TILE_W, 20, bits per tile value.
- NUM_TILES, 16, tiles per board.
- BOARD_W, TILE_W*NUM_TILES (320), packed board width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- char_in  input  8  ASCII character.
- char_valid  input  1  char_in is valid this cycle.
- char_ready  output  1  block accepts char_in; a transfer occurs when char_valid && char_ready.
- board  output  BOARD_W  last successfully parsed board. Tile k occupies bits [TILE_W*k+TILE_W-1 : TILE_W*k]; tile 0 is top-left.
- board_valid  output  1  one-cycle pulse when board is updated.
- err_valid  output  1  one-cycle pulse on a parse error.
- err_code  output  3  error cause, valid with err_valid; holds its last value otherwise.

Behaviour:
- Reset values: board=0, board_valid=0, err_valid=0, err_code=0, char_ready=1, state=IDLE, tile_idx=0, accumulator=0.
- Character classes:
  - digit is '0'..'9'
  - separator is ' ' or ','
  - '.' is an empty tile (value 0)
  - '\n' is end of line
  - '\r' is ignored in every state
  - anything else is bad
- States: IDLE (between tiles), NUM (accumulating digits), PUBLISH, SKIP.
- IDLE:
  - digit: acc=d, go to NUM.
  - '.': store 0 into tile[tile_idx], tile_idx++.
  - separator: ignored; repeated separators are allowed.
  - '\n': end of line.
  - bad: error.
- NUM:
  - digit: acc=acc*10+d. Compute the product/sum at TILE_W+4 bits. If the result exceeds 2^TILE_W-1, latch the overflow flag; acc saturates.
  - separator: store acc into tile[tile_idx], tile_idx++, go to IDLE.
  - '\n': store acc, then end of line.
  - '.' or bad: error.
- Store with tile_idx==NUM_TILES: error code 3 (too many tiles), go to SKIP.
- Overflow flag set at store time: error code 2, go to SKIP.
- End of line:
  - Tile count == NUM_TILES: go to PUBLISH.
  - Tile count == 0 (blank line): silently return to IDLE.
  - Otherwise: error code 4 (too few tiles). Partial tiles are discarded and the state returns to IDLE.
- Bad char: error code 1, go to SKIP.
- PUBLISH:
  - Occupies exactly one cycle.
  - char_ready=0.
  - board <= staging register; board_valid=1 in the same cycle.
  - Next state is IDLE with tile_idx=0 and acc=0.
- Latency: board_valid is asserted in the cycle after the '\n' transfer.
- SKIP:
  - Discard all characters until '\n'.
  - On '\n', return to IDLE with tile_idx=0, acc=0 and the overflow flag cleared.
  - No further errors are reported within that line.
- Errors:
  - err_valid pulses in the cycle after the offending transfer.
  - board is never modified by a failed line.
- char_ready is 1 in every state except PUBLISH.
- Asserting rst_n low mid-line discards all partial state, including the staging register, and returns every output to its reset value.

Optional Feature:
- Macro: STRING_TO_BOARD_POW2_CHECK_EN.
- When defined, every stored tile value must be 0 or a power of two >= 2. A violating value raises error code 5 and the parser goes to SKIP. The check is a single-cycle popcount test at store time.
- When undefined, any value <= 2^TILE_W-1 is accepted and code 5 is never produced.

Decomposition:
- Shared package (game_pkg): TILE_W, NUM_TILES, BOARD_W, parser state enum, err_code constants (ERR_NONE=0, ERR_BAD_CHAR=1, ERR_OVERFLOW=2, ERR_TOO_MANY=3, ERR_TOO_FEW=4, ERR_NOT_POW2=5), ASCII constants.
- One sub-module: ascii_dec_accum. It holds the accumulator, the x10+d datapath, the overflow flag and the clear/load controls. The FSM, tile indexing and staging register stay in the top module.

Test Plan:
- Line "2 0 0 4 0 0 0 0 8 0 0 0 0 0 0 2048\n" at one char per cycle -> one board_valid pulse one cycle after '\n'; tile0=2, tile3=4, tile8=8, tile15=2048, all other tiles 0; char_ready low only in the PUBLISH cycle.
- Comma/dot form "2,.,.,.,.,.,.,.,.,.,.,.,.,.,.,4\r\n" -> tile0=2, tile15=4, board_valid pulse; '\r' has no effect.
- "1048576" as tile 0, rest valid -> err_valid with code 2; board unchanged. A following valid line publishes normally.
- 15 tiles then '\n' -> code 4. 17 tiles -> code 3 at the 17th store, rest of line skipped. Blank "\n" -> no pulse on either output.
- "2 x ..." -> code 1, SKIP to '\n'. rst_n pulsed low after 8 tiles, then a full valid line -> board equals the new line only.
- With STRING_TO_BOARD_POW2_CHECK_EN, tile value 6 -> code 5. Without the macro, the same line publishes with tile=6.
